// File: rtl/lsu_rmw.sv
// -----------------------------------------------------------------------------
// lsu_rmw
//
// Sequenced load/store unit datapath between the execute stage and a
// word-wide data memory port. One request is handled at a time:
//   * loads read the containing word and extract/sign- or zero-extend the
//     addressed field at any byte offset;
//   * sub-word stores do a read-modify-write of the containing word;
//   * full-word stores write directly;
//   * illegal or (optionally) misaligned requests answer with rsp_err and
//     never touch memory.
//
// Optional feature macro: LSU_MISALIGN_TRAP_EN
//   defined   : OFF % SIZE != 0 is reported as an error with no memory access.
//   undefined : the low log2(SIZE) bits of OFF are cleared and the access
//               proceeds aligned; alignment never raises rsp_err.
//
// Parameters
//   XLEN    data / memory word width, 32 or 64
//   ADDR_W  byte address width
//
// Ports
//   clock, reset          sole clock; asynchronous active-high reset
//   req_valid/req_ready   request handshake (ready only while idle)
//   req_store             1 = store, 0 = load
//   req_funct3            access type (LB/LH/LW/LD/LBU/LHU/LWU, SB/SH/SW/SD)
//   req_addr              byte address
//   req_wdata             store data, right-justified
//   rsp_valid             one-cycle completion pulse
//   rsp_rdata             extended load result (0 for stores/errors), held
//   rsp_err               illegal funct3 or misaligned access
//   mem_req/mem_we        registered memory request / write enable
//   mem_addr              word-aligned memory address
//   mem_wdata             full word to write
//   mem_ack               memory completion, sampled while mem_req is high
//   mem_rdata             read word, valid with mem_ack
// -----------------------------------------------------------------------------
module lsu_rmw #(
    parameter int XLEN   = 32,
    parameter int ADDR_W = 32
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_store,
    input  logic [2:0]        req_funct3,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [XLEN-1:0]   req_wdata,
    output logic              rsp_valid,
    output logic [XLEN-1:0]   rsp_rdata,
    output logic              rsp_err,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [XLEN-1:0]   mem_wdata,
    input  logic              mem_ack,
    input  logic [XLEN-1:0]   mem_rdata
);

    localparam int         NB      = XLEN / 8;
    localparam int         OB      = (XLEN == 64) ? 3 : 2;
    // funct3[1:0] encoding of a full-word access (SW for 32, SD for 64)
    localparam logic [1:0] FULL_SZ = (XLEN == 64) ? 2'd3 : 2'd2;

    typedef enum logic [1:0] {
        S_IDLE,
        S_RD,
        S_WR,
        S_RSP
    } state_t;

    state_t            r_state;
    logic              r_ready;
    logic              r_rsp_valid;
    logic [XLEN-1:0]   r_rsp_rdata;
    logic              r_rsp_err;
    logic              r_mem_req;
    logic              r_mem_we;
    logic [ADDR_W-1:0] r_mem_addr;
    logic [XLEN-1:0]   r_mem_wdata;

    // captured request
    logic              r_store;
    logic [2:0]        r_f3;
    logic [OB-1:0]     r_off;
    logic [XLEN-1:0]   r_wdata;

    // -------------------------------------------------------------------------
    // Request decode (only consulted in the accept cycle)
    // -------------------------------------------------------------------------
    logic [OB-1:0] w_off_raw;
    logic [OB-1:0] w_align_mask;
    logic [OB-1:0] w_off;
    logic          w_illegal;
    logic          w_err;
    logic          w_full_store;

    // NOTE: every signal assigned in always_comb gets a default at the top so
    // no path leaves it unassigned, which would otherwise infer a latch.
    always_comb begin
        w_off_raw = req_addr[OB-1:0];

        case (req_funct3[1:0])
            2'd0:    w_align_mask = '0;
            2'd1:    w_align_mask = OB'(1);
            2'd2:    w_align_mask = OB'(3);
            default: w_align_mask = '1;
        endcase

        w_illegal = (req_funct3 == 3'b111) || (req_store && req_funct3[2]);
        // 32-bit words have no LD/SD/LWU
        if (XLEN == 32) begin
            w_illegal = w_illegal || (req_funct3[1:0] == 2'b11)
                                  || (req_funct3 == 3'b110);
        end

`ifdef LSU_MISALIGN_TRAP_EN
        w_off = w_off_raw;
        w_err = w_illegal || (|(w_off_raw & w_align_mask));
`else
        // silently align down to the access size
        w_off = w_off_raw & ~w_align_mask;
        w_err = w_illegal;
`endif

        w_full_store = req_store && !req_funct3[2] && (req_funct3[1:0] == FULL_SZ);
    end

    // -------------------------------------------------------------------------
    // Load extraction and store merge (driven by the captured request)
    // -------------------------------------------------------------------------
    logic [XLEN-1:0] w_shifted;
    logic [XLEN-1:0] w_top;
    logic [XLEN-1:0] w_load_val;
    logic [6:0]      w_pad;
    logic [NB-1:0]   w_bmask;
    logic [XLEN-1:0] w_wsh;
    logic [XLEN-1:0] w_merged;

    always_comb begin
        // bring the addressed field down to bit 0
        w_shifted = mem_rdata >> {r_off, 3'b000};
        // bits above the field; zero for a full-word access
        w_pad     = 7'(XLEN) - (7'd8 << r_f3[1:0]);
        // park the field at the top, then shift back down to extend it
        w_top     = w_shifted << w_pad;
        if (r_f3[2]) begin
            w_load_val = w_top >> w_pad;
        end else begin
            w_load_val = $unsigned($signed(w_top) >>> w_pad);
        end

        case (r_f3[1:0])
            2'd0:    w_bmask = NB'(1);
            2'd1:    w_bmask = NB'(3);
            2'd2:    w_bmask = NB'(15);
            default: w_bmask = '1;
        endcase
        w_bmask = w_bmask << r_off;
        w_wsh   = r_wdata << {r_off, 3'b000};

        w_merged = mem_rdata;
        for (int b = 0; b < NB; b++) begin
            if (w_bmask[b]) begin
                w_merged[8*b +: 8] = w_wsh[8*b +: 8];
            end
        end
    end

    // -------------------------------------------------------------------------
    // Sequencer: IDLE -> (RD) -> (WR) -> RSP -> IDLE, all outputs registered
    // -------------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values and ordering inside the block is irrelevant.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state     <= S_IDLE;
            r_ready     <= 1'b0;
            r_rsp_valid <= 1'b0;
            r_rsp_rdata <= '0;
            r_rsp_err   <= 1'b0;
            r_mem_req   <= 1'b0;
            r_mem_we    <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
            r_store     <= 1'b0;
            r_f3        <= '0;
            r_off       <= '0;
            r_wdata     <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (!r_ready) begin
                        // first cycle out of reset: open the front end
                        r_ready <= 1'b1;
                    end else if (req_valid) begin
                        r_ready <= 1'b0;
                        r_store <= req_store;
                        r_f3    <= req_funct3;
                        r_off   <= w_off;
                        r_wdata <= req_wdata;
                        if (w_err) begin
                            r_state     <= S_RSP;
                            r_rsp_valid <= 1'b1;
                            r_rsp_err   <= 1'b1;
                            r_rsp_rdata <= '0;
                        end else begin
                            r_mem_req  <= 1'b1;
                            r_mem_addr <= {req_addr[ADDR_W-1:OB], {OB{1'b0}}};
                            if (w_full_store) begin
                                r_state     <= S_WR;
                                r_mem_we    <= 1'b1;
                                r_mem_wdata <= req_wdata;
                            end else begin
                                r_state  <= S_RD;
                                r_mem_we <= 1'b0;
                            end
                        end
                    end
                end

                S_RD: begin
                    if (mem_ack) begin
                        if (r_store) begin
                            // keep mem_req high and switch straight to the write
                            r_state     <= S_WR;
                            r_mem_we    <= 1'b1;
                            r_mem_wdata <= w_merged;
                        end else begin
                            r_state     <= S_RSP;
                            r_mem_req   <= 1'b0;
                            r_rsp_valid <= 1'b1;
                            r_rsp_err   <= 1'b0;
                            r_rsp_rdata <= w_load_val;
                        end
                    end
                end

                S_WR: begin
                    if (mem_ack) begin
                        r_state     <= S_RSP;
                        r_mem_req   <= 1'b0;
                        r_mem_we    <= 1'b0;
                        r_rsp_valid <= 1'b1;
                        r_rsp_err   <= 1'b0;
                        r_rsp_rdata <= '0;
                    end
                end

                default: begin  // S_RSP
                    r_state     <= S_IDLE;
                    r_rsp_valid <= 1'b0;
                    r_ready     <= 1'b1;
                end
            endcase
        end
    end

    assign req_ready = r_ready;
    assign rsp_valid = r_rsp_valid;
    assign rsp_rdata = r_rsp_rdata;
    assign rsp_err   = r_rsp_err;
    assign mem_req   = r_mem_req;
    assign mem_we    = r_mem_we;
    assign mem_addr  = r_mem_addr;
    assign mem_wdata = r_mem_wdata;

endmodule

// File: tb/tb_lsu_rmw.sv
// -----------------------------------------------------------------------------
// tb_lsu_rmw
//
// Directed, table-driven bench for lsu_rmw. Two instances (XLEN=32 and
// XLEN=64) share one stimulus bus; sel64 routes valid/ack to one of them and
// selects which outputs are observed. Inputs are driven and outputs sampled
// on the falling clock edge.
// -----------------------------------------------------------------------------
module tb_lsu_rmw;

    localparam int K_ERR  = 0;
    localparam int K_LOAD = 1;
    localparam int K_RMW  = 2;
    localparam int K_FULL = 3;

    typedef struct packed {
        logic        sel64;
        logic        store;
        logic [2:0]  f3;
        logic [31:0] addr;
        logic [63:0] wdata;
        logic [63:0] mrd;       // word returned by memory on a read
        logic [1:0]  kind;
        logic [63:0] exp_rd;    // expected rsp_rdata
        logic [31:0] exp_maddr; // expected mem_addr
        logic [63:0] exp_wd;    // expected mem_wdata on the write
    } vec_t;

    logic        clk;
    logic        rst;
    logic        sel64;
    logic        req_valid;
    logic        req_store;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr;
    logic [63:0] req_wdata;
    logic        mem_ack;
    logic [63:0] mem_rdata;

    logic        a_ready, a_rsp_valid, a_rsp_err, a_mem_req, a_mem_we;
    logic [31:0] a_rsp_rdata, a_mem_addr, a_mem_wdata;
    logic        b_ready, b_rsp_valid, b_rsp_err, b_mem_req, b_mem_we;
    logic [63:0] b_rsp_rdata, b_mem_wdata;
    logic [31:0] b_mem_addr;

    lsu_rmw #(.XLEN(32), .ADDR_W(32)) u_dut32 (
        .clock      (clk),
        .reset      (rst),
        .req_valid  (req_valid & ~sel64),
        .req_ready  (a_ready),
        .req_store  (req_store),
        .req_funct3 (req_funct3),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata[31:0]),
        .rsp_valid  (a_rsp_valid),
        .rsp_rdata  (a_rsp_rdata),
        .rsp_err    (a_rsp_err),
        .mem_req    (a_mem_req),
        .mem_we     (a_mem_we),
        .mem_addr   (a_mem_addr),
        .mem_wdata  (a_mem_wdata),
        .mem_ack    (mem_ack & ~sel64),
        .mem_rdata  (mem_rdata[31:0])
    );

    lsu_rmw #(.XLEN(64), .ADDR_W(32)) u_dut64 (
        .clock      (clk),
        .reset      (rst),
        .req_valid  (req_valid & sel64),
        .req_ready  (b_ready),
        .req_store  (req_store),
        .req_funct3 (req_funct3),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .rsp_valid  (b_rsp_valid),
        .rsp_rdata  (b_rsp_rdata),
        .rsp_err    (b_rsp_err),
        .mem_req    (b_mem_req),
        .mem_we     (b_mem_we),
        .mem_addr   (b_mem_addr),
        .mem_wdata  (b_mem_wdata),
        .mem_ack    (mem_ack & sel64),
        .mem_rdata  (mem_rdata)
    );

    logic        t_ready, t_rsp_valid, t_rsp_err, t_mem_req, t_mem_we;
    logic [63:0] t_rsp_rdata, t_mem_wdata;
    logic [31:0] t_mem_addr;

    assign t_ready     = sel64 ? b_ready     : a_ready;
    assign t_rsp_valid = sel64 ? b_rsp_valid : a_rsp_valid;
    assign t_rsp_err   = sel64 ? b_rsp_err   : a_rsp_err;
    assign t_mem_req   = sel64 ? b_mem_req   : a_mem_req;
    assign t_mem_we    = sel64 ? b_mem_we    : a_mem_we;
    assign t_mem_addr  = sel64 ? b_mem_addr  : a_mem_addr;
    assign t_rsp_rdata = sel64 ? b_rsp_rdata : {32'h0, a_rsp_rdata};
    assign t_mem_wdata = sel64 ? b_mem_wdata : {32'h0, a_mem_wdata};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_vec = 0;
    int n_bad = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%h, expected 0x%h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic s64, input logic st, input logic [2:0] f3,
                                input logic [31:0] addr, input logic [63:0] wd,
                                input logic [63:0] mrd, input int kind,
                                input logic [63:0] exp_rd, input logic [31:0] exp_maddr,
                                input logic [63:0] exp_wd);
        vec_t v;
        v.sel64 = s64;   v.store = st;   v.f3 = f3;   v.addr = addr;
        v.wdata = wd;    v.mrd = mrd;    v.kind = 2'(kind);
        v.exp_rd = exp_rd;  v.exp_maddr = exp_maddr;  v.exp_wd = exp_wd;
        return v;
    endfunction

    // Apply one request, act as the memory (ack after dly wait cycles in
    // each phase), and compare everything observed against the record.
    task automatic run(input string tag, input vec_t v, input int dly);
        int          cyc;
        int          ph;
        int          lat;
        int          exp_lat;
        logic        saw_rd, saw_wr, prev_req, prev_we;
        logic [31:0] rd_addr, wr_addr;
        logic [63:0] wr_data;

        sel64 = v.sel64;
        cyc = 0;
        while (!t_ready && cyc < 20) begin
            @(negedge clk);
            cyc++;
        end
        check({tag, " ready_before"}, 64'(t_ready), 64'd1);

        req_valid  = 1'b1;
        req_store  = v.store;
        req_funct3 = v.f3;
        req_addr   = v.addr;
        req_wdata  = v.wdata;
        mem_rdata  = v.mrd;
        @(negedge clk);
        // junk on the request bus must be ignored after accept
        req_valid  = 1'b0;
        req_store  = ~v.store;
        req_funct3 = 3'b111;
        req_addr   = 32'hFFFF_FFFF;
        req_wdata  = '1;

        cyc = 1; ph = 0; lat = 0;
        saw_rd = 1'b0; saw_wr = 1'b0; prev_req = 1'b0; prev_we = 1'b0;
        rd_addr = '0; wr_addr = '0; wr_data = '0;
        while (lat == 0 && cyc < 40) begin
            mem_ack = 1'b0;
            if (t_mem_req) begin
                if (!prev_req || (t_mem_we != prev_we)) ph = 0;
                if (t_mem_we) begin
                    saw_wr = 1'b1; wr_addr = t_mem_addr; wr_data = t_mem_wdata;
                end else begin
                    saw_rd = 1'b1; rd_addr = t_mem_addr;
                end
                mem_ack = (ph >= dly);
                ph++;
            end
            prev_req = t_mem_req;
            prev_we  = t_mem_we;
            if (t_rsp_valid) begin
                lat = cyc;
                check({tag, " rsp_err"},   64'(t_rsp_err), 64'(v.kind == K_ERR));
                check({tag, " rsp_rdata"}, t_rsp_rdata, v.exp_rd);
                check({tag, " ready_during_rsp"}, 64'(t_ready), 64'd0);
            end else begin
                @(negedge clk);
                cyc++;
            end
        end

        case (v.kind)
            K_ERR:   exp_lat = 1;
            K_LOAD:  exp_lat = 2 + dly;
            K_RMW:   exp_lat = 3 + 2 * dly;
            default: exp_lat = 2 + dly;
        endcase
        check({tag, " latency"}, 64'(lat), 64'(exp_lat));
        check({tag, " read_issued"},  64'(saw_rd), 64'(v.kind == K_LOAD || v.kind == K_RMW));
        check({tag, " write_issued"}, 64'(saw_wr), 64'(v.kind == K_RMW || v.kind == K_FULL));
        if (v.kind == K_LOAD || v.kind == K_RMW)
            check({tag, " read_addr"}, 64'(rd_addr), 64'(v.exp_maddr));
        if (v.kind == K_RMW || v.kind == K_FULL) begin
            check({tag, " write_addr"},  64'(wr_addr), 64'(v.exp_maddr));
            check({tag, " write_data"},  wr_data, v.exp_wd);
        end

        @(negedge clk);
        mem_ack = 1'b0;
        check({tag, " rsp_pulse_end"}, 64'(t_rsp_valid), 64'd0);
        check({tag, " ready_after"},   64'(t_ready), 64'd1);
    endtask

    vec_t vecs[$];

    initial begin
        int cnt;

        // ---------------- vector table ----------------
        // XLEN=32 loads
        vecs.push_back(mk(0, 0, 3'b000, 32'h103, 0, 64'h80FF_1234, K_LOAD, 64'hFFFF_FF80, 32'h100, 0));
        vecs.push_back(mk(0, 0, 3'b100, 32'h103, 0, 64'h80FF_1234, K_LOAD, 64'h0000_0080, 32'h100, 0));
        vecs.push_back(mk(0, 0, 3'b001, 32'h102, 0, 64'h80FF_1234, K_LOAD, 64'hFFFF_80FF, 32'h100, 0));
        vecs.push_back(mk(0, 0, 3'b101, 32'h100, 0, 64'h80FF_1234, K_LOAD, 64'h0000_1234, 32'h100, 0));
        vecs.push_back(mk(0, 0, 3'b010, 32'h200, 0, 64'hDEAD_BEEF, K_LOAD, 64'hDEAD_BEEF, 32'h200, 0));
        vecs.push_back(mk(0, 0, 3'b000, 32'h001, 0, 64'h0000_7F00, K_LOAD, 64'h0000_007F, 32'h000, 0));
        // XLEN=32 stores
        vecs.push_back(mk(0, 1, 3'b001, 32'h202, 64'h5555_ABCD, 64'h1122_3344, K_RMW, 0, 32'h200, 64'hABCD_3344));
        vecs.push_back(mk(0, 1, 3'b000, 32'h301, 64'hFFFF_FF5A, 64'h1122_3344, K_RMW, 0, 32'h300, 64'h1122_5A44));
        vecs.push_back(mk(0, 1, 3'b010, 32'h404, 64'hCAFE_F00D, 64'h0,         K_FULL, 0, 32'h404, 64'hCAFE_F00D));
        // XLEN=32 illegal: SD, LD, LWU, funct3=111, store with funct3[2]
        vecs.push_back(mk(0, 1, 3'b011, 32'h500, 64'h1234, 0, K_ERR, 0, 0, 0));
        vecs.push_back(mk(0, 0, 3'b011, 32'h500, 0, 0, K_ERR, 0, 0, 0));
        vecs.push_back(mk(0, 0, 3'b110, 32'h500, 0, 0, K_ERR, 0, 0, 0));
        vecs.push_back(mk(0, 0, 3'b111, 32'h500, 0, 0, K_ERR, 0, 0, 0));
        vecs.push_back(mk(0, 1, 3'b100, 32'h500, 0, 0, K_ERR, 0, 0, 0));
        // XLEN=32 misaligned accesses
`ifdef LSU_MISALIGN_TRAP_EN
        vecs.push_back(mk(0, 0, 3'b010, 32'h101, 0, 64'h1122_3344, K_ERR, 0, 0, 0));
        vecs.push_back(mk(0, 0, 3'b001, 32'h103, 0, 64'hAABB_CCDD, K_ERR, 0, 0, 0));
        vecs.push_back(mk(0, 1, 3'b001, 32'h201, 64'h1234, 64'hAABB_CCDD, K_ERR, 0, 0, 0));
`else
        vecs.push_back(mk(0, 0, 3'b010, 32'h101, 0, 64'h1122_3344, K_LOAD, 64'h1122_3344, 32'h100, 0));
        vecs.push_back(mk(0, 0, 3'b001, 32'h103, 0, 64'hAABB_CCDD, K_LOAD, 64'hFFFF_AABB, 32'h100, 0));
        vecs.push_back(mk(0, 1, 3'b001, 32'h201, 64'h1234, 64'hAABB_CCDD, K_RMW, 0, 32'h200, 64'hAABB_1234));
`endif
        // XLEN=64
        vecs.push_back(mk(1, 0, 3'b110, 32'h004, 0, 64'h8765_4321_0000_0000, K_LOAD, 64'h0000_0000_8765_4321, 32'h000, 0));
        vecs.push_back(mk(1, 0, 3'b010, 32'h004, 0, 64'h8765_4321_0000_0000, K_LOAD, 64'hFFFF_FFFF_8765_4321, 32'h000, 0));
        vecs.push_back(mk(1, 0, 3'b011, 32'h010, 0, 64'h0123_4567_89AB_CDEF, K_LOAD, 64'h0123_4567_89AB_CDEF, 32'h010, 0));
        vecs.push_back(mk(1, 0, 3'b000, 32'h007, 0, 64'h7F00_0000_0000_0000, K_LOAD, 64'h0000_0000_0000_007F, 32'h000, 0));
        vecs.push_back(mk(1, 1, 3'b010, 32'h104, 64'hDEAD_BEEF, 64'h1111_1111_2222_2222, K_RMW, 0, 32'h100, 64'hDEAD_BEEF_2222_2222));
        vecs.push_back(mk(1, 1, 3'b011, 32'h208, 64'h0123_4567_89AB_CDEF, 0, K_FULL, 0, 32'h208, 64'h0123_4567_89AB_CDEF));
        vecs.push_back(mk(1, 0, 3'b111, 32'h000, 0, 0, K_ERR, 0, 0, 0));

        // ---------------- reset state ----------------
        sel64 = 1'b0; req_valid = 1'b0; req_store = 1'b0; req_funct3 = '0;
        req_addr = '0; req_wdata = '0; mem_ack = 1'b0; mem_rdata = '0;
        rst = 1'b0;
        #1 rst = 1'b1;
        @(negedge clk);
        @(negedge clk);
        check("reset ready",     64'(a_ready),     64'd0);
        check("reset rsp_valid", 64'(a_rsp_valid), 64'd0);
        check("reset rsp_err",   64'(a_rsp_err),   64'd0);
        check("reset rsp_rdata", 64'(a_rsp_rdata), 64'd0);
        check("reset mem_req",   64'(a_mem_req),   64'd0);
        check("reset mem_we",    64'(a_mem_we),    64'd0);
        check("reset mem_addr",  64'(a_mem_addr),  64'd0);
        check("reset mem_wdata", 64'(a_mem_wdata), 64'd0);
        check("reset ready64",   64'(b_ready),     64'd0);
        rst = 1'b0;
        @(negedge clk);
        check("ready after release",   64'(a_ready), 64'd1);
        check("ready64 after release", 64'(b_ready), 64'd1);

        // ---------------- table ----------------
        for (int i = 0; i < vecs.size(); i++) begin
            run($sformatf("v%0d", i), vecs[i], 0);
        end

        // ---------------- ack wait cycles ----------------
        run("dly_lb", vecs[0], 2);
        run("dly_sh", vecs[6], 1);
        run("dly_sw", vecs[8], 3);

        // ---------------- stray mem_ack while idle ----------------
        sel64 = 1'b0;
        mem_ack = 1'b1;
        @(negedge clk);
        @(negedge clk);
        check("stray_ack rsp_valid", 64'(a_rsp_valid), 64'd0);
        check("stray_ack mem_req",   64'(a_mem_req),   64'd0);
        check("stray_ack ready",     64'(a_ready),     64'd1);
        mem_ack = 1'b0;

        // ---------------- reset during WR wait of a full-word store ----------------
        req_valid = 1'b1; req_store = 1'b1; req_funct3 = 3'b010;
        req_addr = 32'h600; req_wdata = 64'h1234_5678;
        @(negedge clk);
        req_valid = 1'b0;
        check("rst_wr mem_req", 64'(a_mem_req), 64'd1);
        check("rst_wr mem_we",  64'(a_mem_we),  64'd1);
        @(negedge clk);
        @(negedge clk);
        #1 rst = 1'b1;
        #1;
        check("rst_wr mem_req drops", 64'(a_mem_req), 64'd0);
        check("rst_wr mem_we drops",  64'(a_mem_we),  64'd0);
        check("rst_wr ready in rst",  64'(a_ready),   64'd0);
        @(negedge clk);
        check("rst_wr no rsp", 64'(a_rsp_valid), 64'd0);
        rst = 1'b0;
        @(negedge clk);
        check("rst_wr ready after", 64'(a_ready),     64'd1);
        check("rst_wr no rsp after", 64'(a_rsp_valid), 64'd0);

        // ---------------- reset during the write phase of a sub-word store ----------------
        req_valid = 1'b1; req_store = 1'b1; req_funct3 = 3'b000;
        req_addr = 32'h702; req_wdata = 64'hEE; mem_rdata = 64'h4444_4444;
        @(negedge clk);
        req_valid = 1'b0;
        mem_ack = 1'b1;                 // acknowledge the read
        @(negedge clk);
        mem_ack = 1'b0;
        check("rst_rmw in write", 64'(a_mem_we), 64'd1);
        check("rst_rmw merged",   64'(a_mem_wdata), 64'h44EE_4444);
        #1 rst = 1'b1;
        #1;
        check("rst_rmw mem_req drops", 64'(a_mem_req), 64'd0);
        @(negedge clk);
        rst = 1'b0;
        cnt = 0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            if (a_rsp_valid || a_mem_req) cnt++;
        end
        check("rst_rmw quiet after", 64'(cnt), 64'd0);

        // transaction after reset still works
        run("post_rst", vecs[1], 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

    // hard time limit so the run always ends
    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

endmodule
